// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide with pipeline stall control.
// One result per operation, presented in RESULT with a one-cycle DONE pulse.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FINAL, S_DONE} state_t;

  state_t          state, next_state;
  logic [2:0]      op;
  logic [XLEN-1:0] opa, opb, addend, acc_hi, acc_lo;
  logic            neg1, neg2;
  logic [CW-1:0]   count;

  logic            is_div, sign1, sign2, a_neg, b_neg, special;
  logic [XLEN-1:0] a_mag, b_mag, quo, rem, final_value;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] product;

  always_comb begin
    is_div  = op[2];
    sign1   = ~(op[0] & (op[1] | op[2]));
    sign2   = op[2] ? ~op[0] : ~op[1];
    a_neg   = sign1 & opa[XLEN-1];
    b_neg   = sign2 & opb[XLEN-1];
    a_mag   = a_neg ? -opa : opa;
    b_mag   = b_neg ? -opb : opb;
    // Divide-by-zero and signed overflow have fixed architectural results.
    special = is_div & ((opb == '0) |
              (~op[0] & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (opb == '1)));
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, addend};
    product   = {acc_hi, acc_lo};
    if (neg1 ^ neg2)
      product = -product;
    quo = (neg1 ^ neg2) ? -acc_lo : acc_lo;
    rem = neg1 ? -acc_hi : acc_hi;
  end

  always_comb begin
    final_value = '0;
    if (special) begin
      if (opb == '0)
        final_value = op[1] ? opa : '1;
      else
        final_value = op[1] ? '0 : opa;
    end else if (is_div)
      final_value = op[1] ? rem : quo;
    else if (op == 3'b000)
      final_value = product[XLEN-1:0];
    else
      final_value = product[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start && !flush) next_state = S_PREP;
      S_PREP:  next_state = flush ? S_IDLE : (special ? S_FINAL : S_CALC);
      S_CALC:  if (flush) next_state = S_IDLE;
               else if (count == CW'(XLEN-1)) next_state = S_FINAL;
      S_FINAL: next_state = flush ? S_IDLE : S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stall = ((state == S_IDLE) & start & ~flush) |
            (state == S_PREP) | (state == S_CALC) | (state == S_FINAL);
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  // acc_hi/acc_lo hold product hi/lo for multiply and remainder/quotient for divide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      addend <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op  <= funct3;
            opa <= operand1;
            opb <= operand2;
          end
        end
        S_PREP: begin
          neg1   <= a_neg;
          neg2   <= b_neg;
          acc_hi <= '0;
          acc_lo <= is_div ? a_mag : b_mag;
          addend <= is_div ? b_mag : a_mag;
          count  <= '0;
        end
        S_CALC: begin
          count <= count + 1'b1;
          if (is_div) begin
            if (!div_diff[XLEN]) begin
              acc_hi <= div_diff[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end
        end
        S_FINAL: if (!flush) result <= final_value;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: hand-computed RV32M results, latency, stall, flush and reset.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .operand1 (operand1),
    .operand2 (operand2),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Cycle 0 is the cycle START is high; operands are scrambled afterwards to prove they were latched.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input bit hold, input logic [31:0] exp_res,
                               input int exp_done);
    int          done_cyc;
    int          stall_low;
    logic [31:0] res;
    logic        stall0;
    done_cyc  = -1;
    stall_low = -1;
    res       = '0;
    @(negedge clk);
    funct3 = f; operand1 = a; operand2 = b; start = 1'b1;
    #1;
    stall0 = stall;
    for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      operand1 = ~a; operand2 = b ^ 32'h5; funct3 = ~f;
      #1;
      if (!stall && stall_low < 0) stall_low = cyc;
      if (done) begin
        done_cyc = cyc;
        res      = result;
      end
    end
    checkOutput({tag, "_stall0"}, {31'b0, stall0}, 32'd1);
    checkOutput({tag, "_done_cycle"}, done_cyc, exp_done);
    checkOutput({tag, "_stall_low"}, stall_low, exp_done);
    checkOutput({tag, "_result"}, res, exp_res);
  endtask

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    reset = 1'b1;

    applyStimulus("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 35);
    @(negedge clk); #1;
    checkOutput("mul_done_pulse", {31'b0, done}, 32'd0);
    checkOutput("mul_idle_busy", {31'b0, busy}, 32'd0);

    applyStimulus("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 35);
    applyStimulus("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 35);
    applyStimulus("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFF, 35);
    applyStimulus("mulh_pos", 3'b001, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 35);
    applyStimulus("mulhu_msb", 3'b011, 32'h80000000, 32'd4, 1'b0, 32'h00000002, 35);
    applyStimulus("div", 3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 35);
    applyStimulus("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 35);
    applyStimulus("div_negdiv", 3'b100, 32'd20, 32'hFFFFFFFA, 1'b0, 32'hFFFFFFFD, 35);
    applyStimulus("rem_negdiv", 3'b110, 32'd20, 32'hFFFFFFFA, 1'b0, 32'h00000002, 35);
    applyStimulus("divu", 3'b101, 32'd100, 32'd7, 1'b0, 32'd14, 35);
    applyStimulus("divu0", 3'b101, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 3);
    applyStimulus("rem0", 3'b110, 32'd5, 32'd0, 1'b0, 32'd5, 3);
    applyStimulus("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 3);
    applyStimulus("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 3);
    applyStimulus("remu", 3'b111, 32'd100, 32'd7, 1'b0, 32'd2, 35);

    // Flush a DIV in cycle 10; RESULT must keep the REMU value.
    @(negedge clk);
    funct3 = 3'b100; operand1 = 32'hFFFFFFF9; operand2 = 32'd2; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_stall", {31'b0, stall}, 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) dones++;
    end
    checkOutput("flush_no_done", dones, 32'd0);
    checkOutput("flush_result_kept", result, 32'd2);

    // Reset low in cycle 20 of a MUL.
    @(negedge clk);
    funct3 = 3'b000; operand1 = 32'd7; operand2 = 32'hFFFFFFFD; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 20) reset = 1'b0;
    end
    @(negedge clk); #1;
    checkOutput("midrst_stall", {31'b0, stall}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    reset = 1'b1;

    // Back-to-back: START held through the first DONE; second op accepted in cycle 36.
    applyStimulus("b2b_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 35);
    applyStimulus("b2b_divu", 3'b101, 32'd100, 32'd7, 1'b0, 32'd14, 35);
    @(negedge clk); #1;
    checkOutput("b2b_single_done", {31'b0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
